pc_sequencer: RTL

- Fetch/redirect controller for the 16-bit stack machine.
- Owns the program counter and runs instruction-memory fetches through a req/ack handshake.
- Presents each fetched instruction to the decoder, then commits the next PC:
  - sequential: PC+1;
  - branch or call: PC + sign-extended 11-bit word offset;
  - return: popped from an internal return-address stack.
- Sits between instruction memory and the decode/control unit. It is the sequencing consumer of the 11b→16b immediate sign extension.

---
 rtl/pc_sequencer_if.sv | 10 +
 rtl/pc_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus between the PC sequencer (master) and instruction memory (slave).
interface pc_sequencer_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/redirect controller: owns the PC, fetches over req/ack, presents the instruction
// to the decoder and commits sequential, relative (branch/call) or return-stack next PC.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          RS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    pc_sequencer_if.master     imem,
    output logic               instr_valid,
    output logic [15:0]        instr,
    output logic [15:0]        pc,
    input  logic               stall,
    input  logic               br_taken,
    input  logic               call,
    input  logic               ret,
    input  logic [10:0]        offset,
    output logic               rs_overflow,
    output logic               rs_underflow
);
    localparam int AW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            req_en;
    logic [15:0]     pc_d;
    logic [CW-1:0]   count, count_d;
    logic [15:0]     rs [RS_DEPTH];
    logic            push, instr_ld, ovf_set, unf_set;
    logic [15:0]     pc_inc, pc_rel, rs_top;

    function automatic logic [15:0] sext11(input logic signed [10:0] off);
        logic signed [15:0] ext;
        ext = off;
        return ext;
    endfunction

    assign pc_inc = pc + 16'd1;
    assign pc_rel = pc + sext11(offset);
    assign rs_top = rs[AW'(count - CW'(1))];

    // State register and sequencing state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            req_en       <= 1'b0;
            pc           <= RESET_PC;
            instr        <= 16'h0000;
            count        <= '0;
            rs_overflow  <= 1'b0;
            rs_underflow <= 1'b0;
        end else begin
            state_q <= state_d;
            req_en  <= 1'b1;
            pc      <= pc_d;
            count   <= count_d;
            if (instr_ld) instr <= imem.imem_data;
            if (ovf_set) rs_overflow <= 1'b1;
            if (unf_set) rs_underflow <= 1'b1;
        end
    end

    // Stack storage is data only; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) rs[AW'(count)] <= pc_inc;
    end

    // Next-state and commit decision
    always_comb begin
        state_d  = state_q;
        pc_d     = pc;
        count_d  = count;
        push     = 1'b0;
        instr_ld = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem.imem_ack) begin
                    instr_ld = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    state_d = FETCH;
                    if (ret) begin
                        if (count != '0) begin
                            pc_d    = rs_top;
                            count_d = count - CW'(1);
                        end else begin
                            pc_d    = pc_inc;
                            unf_set = 1'b1;
                        end
                    end else if (call) begin
                        pc_d = pc_rel;
                        if (count < CW'(RS_DEPTH)) begin
                            push    = 1'b1;
                            count_d = count + CW'(1);
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end else if (br_taken) begin
                        pc_d = pc_rel;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
        endcase
    end

    // Outputs; req_en keeps the request low until the first edge after reset
    always_comb begin
        imem.imem_req  = req_en && (state_q == FETCH);
        imem.imem_addr = pc;
        instr_valid    = (state_q == EXEC);
    end
endmodule
